// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the iCache/dCache memory port arbiter.
package mem_arbiter_pkg;

  localparam int WORD_W     = 32;
  localparam int LINE_WORDS = 8;

  // Master IDs, also used as the owner / last-grant register encoding
  localparam logic IMASTER = 1'b0;
  localparam logic DMASTER = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // Burst counter width; at least one bit so MAX_BURST=1 still elaborates
  function automatic int burst_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational winner select between iCache and dCache requests.
module rr_pick
  import mem_arbiter_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic i_ireq,
  input  logic i_dreq,
  input  logic i_last,
  output logic o_pick
);

  // Single requester wins outright; on a tie either alternate or favour dCache
  always_comb begin
    o_pick = IMASTER;
    if (i_dreq && !i_ireq)
      o_pick = DMASTER;
    else if (i_dreq && i_ireq)
      o_pick = (RR_EN != 0) ? ~i_last : DMASTER;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (iCache/dCache) arbiter onto a single addr_ok/data_ok memory port.
// One transaction outstanding; an owner may burst up to MAX_BURST transactions.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int RR_EN     = 1,
  parameter int MAX_BURST = LINE_WORDS
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_req,
  input  logic [WORD_W-1:0] i_addr,
  output logic [WORD_W-1:0] i_rdata,
  output logic              i_addr_ok,
  output logic              i_data_ok,
  input  logic              d_req,
  input  logic              d_wen,
  input  logic [WORD_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic [WORD_W-1:0] d_rdata,
  output logic              d_addr_ok,
  output logic              d_data_ok,
  output logic              mem_req,
  output logic              mem_wen,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  output logic              gnt_d
);

  localparam int            BW         = burst_w(MAX_BURST);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  state_t        r_state;
  logic          r_owner;
  logic          r_last;
  logic [BW-1:0] r_burst;

  logic w_pick;
  logic w_owner;
  logic w_owner_req;
  logic w_mem_req;
  logic w_accept;
  logic w_done;

  rr_pick #(.RR_EN(RR_EN)) u_pick (
    .i_ireq (i_req),
    .i_dreq (d_req),
    .i_last (r_last),
    .o_pick (w_pick)
  );

  // In IDLE the fresh winner drives the port directly; otherwise the latched owner.
  // Everything visible is gated by resetn so reset clears outputs immediately.
  always_comb begin
    w_owner     = (r_state == ST_IDLE) ? w_pick : r_owner;
    w_owner_req = (w_owner == DMASTER) ? d_req : i_req;
    w_mem_req   = resetn && (r_state != ST_DATA) && w_owner_req;
    w_accept    = w_mem_req && mem_addr_ok;
    w_done      = resetn && (r_state == ST_DATA) && mem_data_ok;
  end

  assign mem_req   = w_mem_req;
  assign mem_wen   = w_mem_req && (w_owner == DMASTER) && d_wen;
  assign mem_addr  = (w_owner == DMASTER) ? d_addr : i_addr;
  assign mem_wdata = d_wdata;
  assign i_addr_ok = w_accept && (w_owner == IMASTER);
  assign d_addr_ok = w_accept && (w_owner == DMASTER);
  assign i_data_ok = w_done && (r_owner == IMASTER);
  assign d_data_ok = w_done && (r_owner == DMASTER);
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign gnt_d     = resetn && (w_owner == DMASTER) && ((r_state != ST_IDLE) || w_mem_req);

  // Ownership FSM with burst counter; last-grant updates only when a tenure ends on data
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_owner <= IMASTER;
      r_last  <= IMASTER;
      r_burst <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_mem_req) begin
            r_owner <= w_pick;
            r_state <= mem_addr_ok ? ST_DATA : ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (!w_owner_req) begin
            r_state <= ST_IDLE;
            r_burst <= '0;
          end else if (mem_addr_ok) begin
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (mem_data_ok) begin
            if (w_owner_req && (r_burst < BURST_LAST)) begin
              r_state <= ST_ADDR;
              r_burst <= r_burst + 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_burst <= '0;
              r_last  <= r_owner;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_burst <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: round-robin (idx 0) and fixed-priority (idx 1) instances
// on shared stimulus, a tenure-level model checked every cycle, plus literal checks.
module tb_mem_arbiter;

  localparam int MB = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req, d_req, d_wen, mem_addr_ok, mem_data_ok;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;

  logic [31:0] o_irdata[2], o_drdata[2], o_maddr[2], o_mwdata[2];
  logic        o_iaok[2], o_idok[2], o_daok[2], o_ddok[2], o_mreq[2], o_mwen[2], o_gntd[2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.RR_EN(1), .MAX_BURST(MB)) u_rr (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(o_irdata[0]), .i_addr_ok(o_iaok[0]), .i_data_ok(o_idok[0]),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(o_drdata[0]),
    .d_addr_ok(o_daok[0]), .d_data_ok(o_ddok[0]),
    .mem_req(o_mreq[0]), .mem_wen(o_mwen[0]), .mem_addr(o_maddr[0]), .mem_wdata(o_mwdata[0]),
    .mem_rdata(mem_rdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .gnt_d(o_gntd[0])
  );

  mem_arbiter #(.RR_EN(0), .MAX_BURST(MB)) u_fx (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(o_irdata[1]), .i_addr_ok(o_iaok[1]), .i_data_ok(o_idok[1]),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(o_drdata[1]),
    .d_addr_ok(o_daok[1]), .d_data_ok(o_ddok[1]),
    .mem_req(o_mreq[1]), .mem_wen(o_mwen[1]), .mem_addr(o_maddr[1]), .mem_wdata(o_mwdata[1]),
    .mem_rdata(mem_rdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .gnt_d(o_gntd[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // ---------------- tenure-level model (0 = iCache, 1 = dCache) ----------------
  logic m_busy[2], m_wait[2], m_own[2], m_last[2];
  int   m_cnt[2];

  function automatic logic win(input int k);
    if (i_req && !d_req) return 1'b0;
    if (d_req && !i_req) return 1'b1;
    return (k == 0) ? !m_last[k] : 1'b1;
  endfunction

  function automatic logic oreq(input logic who);
    return who ? d_req : i_req;
  endfunction

  always @(posedge clk or negedge resetn) begin
    for (int k = 0; k < 2; k++) begin
      if (!resetn) begin
        m_busy[k] <= 1'b0; m_wait[k] <= 1'b0; m_own[k] <= 1'b0; m_last[k] <= 1'b0; m_cnt[k] <= 0;
      end else if (!m_busy[k]) begin
        if (i_req || d_req) begin
          m_busy[k] <= 1'b1; m_own[k] <= win(k); m_wait[k] <= mem_addr_ok; m_cnt[k] <= 0;
        end
      end else if (!m_wait[k]) begin
        if (!oreq(m_own[k])) m_busy[k] <= 1'b0;
        else if (mem_addr_ok) m_wait[k] <= 1'b1;
      end else if (mem_data_ok) begin
        if (oreq(m_own[k]) && (m_cnt[k] + 1 < MB)) begin
          m_cnt[k] <= m_cnt[k] + 1; m_wait[k] <= 1'b0;
        end else begin
          m_busy[k] <= 1'b0; m_wait[k] <= 1'b0; m_last[k] <= m_own[k];
        end
      end
    end
  end

  // Compare both instances against the model on every falling edge
  always @(negedge clk) begin
    logic e_req, e_wen, e_iaok, e_idok, e_daok, e_ddok, e_gnt, who;
    for (int k = 0; k < 2; k++) begin
      e_req = 0; e_wen = 0; e_iaok = 0; e_idok = 0; e_daok = 0; e_ddok = 0; e_gnt = 0; who = 0;
      if (resetn === 1'b1) begin
        if (!m_busy[k]) begin
          if (i_req || d_req) begin who = win(k); e_req = 1; end
        end else begin
          who = m_own[k]; e_gnt = who;
          if (!m_wait[k]) e_req = oreq(who);
          else if (mem_data_ok) begin e_idok = !who; e_ddok = who; end
        end
        if (e_req) begin
          e_gnt = who; e_wen = who && d_wen;
          if (mem_addr_ok) begin e_iaok = !who; e_daok = who; end
        end
      end
      chk($sformatf("model ctl{req,wen,iaok,idok,daok,ddok,gnt} dut%0d", k),
          {25'd0, o_mreq[k], o_mwen[k], o_iaok[k], o_idok[k], o_daok[k], o_ddok[k], o_gntd[k]},
          {25'd0, e_req, e_wen, e_iaok, e_idok, e_daok, e_ddok, e_gnt});
      if (e_req) chk($sformatf("model mem_addr dut%0d", k), o_maddr[k], who ? d_addr : i_addr);
      if (e_wen) chk($sformatf("model mem_wdata dut%0d", k), o_mwdata[k], d_wdata);
      chk($sformatf("model i_rdata dut%0d", k), o_irdata[k], mem_rdata);
      chk($sformatf("model d_rdata dut%0d", k), o_drdata[k], mem_rdata);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drv(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                     input logic [31:0] da, input logic [31:0] dwd,
                     input logic aok, input logic dok, input logic [31:0] rd);
    @(posedge clk); #1;
    i_req = ir; i_addr = ia; d_req = dr; d_wen = dw; d_addr = da; d_wdata = dwd;
    mem_addr_ok = aok; mem_data_ok = dok; mem_rdata = rd;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 0; i_req = 0; d_req = 0; d_wen = 0; mem_addr_ok = 0; mem_data_ok = 0;
    repeat (2) @(posedge clk);
    #1 resetn = 1;
  endtask

  initial begin
    resetn = 0; i_req = 1; d_req = 1; d_wen = 1; mem_addr_ok = 1; mem_data_ok = 1;
    i_addr = 32'h10; d_addr = 32'h20; d_wdata = 0; mem_rdata = 0;
    @(negedge clk);
    chk("reset mem_req", {31'd0, o_mreq[0]}, 0);
    chk("reset gnt_d", {31'd0, o_gntd[0]}, 0);
    chk("reset mem_wen", {31'd0, o_mwen[0]}, 0);
    chk("reset d_addr_ok", {31'd0, o_daok[0]}, 0);
    do_reset();

    // single iCache read, addr accepted at once, data two cycles later
    drv(1, 32'h1000, 0, 0, 0, 0, 1, 0, 0);
    chk("ic i_addr_ok c0", {31'd0, o_iaok[0]}, 1);
    chk("ic mem_addr c0", o_maddr[0], 32'h1000);
    chk("ic gnt_d c0", {31'd0, o_gntd[0]}, 0);
    drv(0, 32'h1000, 0, 0, 0, 0, 0, 0, 0);
    chk("ic i_data_ok c1", {31'd0, o_idok[0]}, 0);
    drv(0, 32'h1000, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
    chk("ic i_data_ok c2", {31'd0, o_idok[0]}, 1);
    chk("ic i_rdata c2", o_irdata[0], 32'hDEADBEEF);
    chk("ic d_data_ok c2", {31'd0, o_ddok[0]}, 0);

    // simultaneous requests after reset: dCache first, then iCache
    do_reset();
    drv(1, 32'h2000, 1, 0, 32'h3000, 0, 1, 0, 0);
    chk("rr first gnt_d", {31'd0, o_gntd[0]}, 1);
    chk("rr first d_addr_ok", {31'd0, o_daok[0]}, 1);
    chk("rr first mem_addr", o_maddr[0], 32'h3000);
    drv(1, 32'h2000, 0, 0, 32'h3000, 0, 0, 1, 32'h1111);
    chk("rr d_data_ok", {31'd0, o_ddok[0]}, 1);
    drv(1, 32'h2000, 0, 0, 32'h3000, 0, 1, 0, 0);
    chk("rr second gnt_d", {31'd0, o_gntd[0]}, 0);
    chk("rr second i_addr_ok", {31'd0, o_iaok[0]}, 1);
    chk("rr second mem_addr", o_maddr[0], 32'h2000);
    drv(0, 32'h2000, 0, 0, 32'h3000, 0, 0, 1, 32'h2222);
    chk("rr i_data_ok", {31'd0, o_idok[0]}, 1);

    // 10 dCache writes against a held iCache request: 8, then iCache, then 2 more
    do_reset();
    for (int n = 0; n < 8; n++) begin
      drv(1, 32'h500, 1, 1, 32'h100 + n, n, 1, 0, 0);
      chk($sformatf("burst%0d d_addr_ok", n), {31'd0, o_daok[0]}, 1);
      chk($sformatf("burst%0d mem_addr", n), o_maddr[0], 32'h100 + n);
      chk($sformatf("burst%0d mem_wen", n), {31'd0, o_mwen[0]}, 1);
      drv(1, 32'h500, 1, 1, 32'h100 + n, n, 0, 1, 0);
      chk($sformatf("burst%0d d_data_ok", n), {31'd0, o_ddok[0]}, 1);
    end
    drv(1, 32'h500, 1, 1, 32'h108, 8, 1, 0, 0);
    chk("burst handoff gnt_d", {31'd0, o_gntd[0]}, 0);
    chk("burst handoff i_addr_ok", {31'd0, o_iaok[0]}, 1);
    chk("burst handoff mem_wen", {31'd0, o_mwen[0]}, 0);
    drv(0, 32'h500, 1, 1, 32'h108, 8, 0, 1, 32'h77);
    chk("burst handoff i_data_ok", {31'd0, o_idok[0]}, 1);
    for (int n = 8; n < 10; n++) begin
      drv(0, 32'h500, 1, 1, 32'h100 + n, n, 1, 0, 0);
      chk($sformatf("tail%0d gnt_d", n), {31'd0, o_gntd[0]}, 1);
      chk($sformatf("tail%0d mem_addr", n), o_maddr[0], 32'h100 + n);
      drv(0, 32'h500, (n == 8), 1, 32'h100 + n, n, 0, 1, 0);
      chk($sformatf("tail%0d d_data_ok", n), {31'd0, o_ddok[0]}, 1);
    end

    // memory stalls the address phase for 5 cycles
    do_reset();
    for (int n = 0; n < 5; n++) begin
      drv(1, 32'h600, 1, 1, 32'h4444, 32'h55AA, 0, 0, 0);
      chk($sformatf("stall%0d mem_addr", n), o_maddr[0], 32'h4444);
      chk($sformatf("stall%0d mem_wdata", n), o_mwdata[0], 32'h55AA);
      chk($sformatf("stall%0d addr_ok", n), {30'd0, o_iaok[0], o_daok[0]}, 0);
    end
    drv(1, 32'h600, 1, 1, 32'h4444, 32'h55AA, 1, 0, 0);
    chk("stall accept d_addr_ok", {31'd0, o_daok[0]}, 1);

    // reset while waiting on data; a late data_ok must be ignored
    @(posedge clk); #1;
    resetn = 0; i_req = 0; d_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    @(negedge clk);
    chk("rst-in-data d_data_ok", {31'd0, o_ddok[0]}, 0);
    chk("rst-in-data gnt_d", {31'd0, o_gntd[0]}, 0);
    @(posedge clk); #1 resetn = 1;
    @(negedge clk);
    chk("late data_ok d_data_ok", {31'd0, o_ddok[0]}, 0);
    chk("late data_ok mem_req", {31'd0, o_mreq[0]}, 0);

    // owner withdraws before the address is accepted
    do_reset();
    drv(0, 0, 1, 0, 32'h700, 0, 0, 0, 0);
    chk("drop mem_req before", {31'd0, o_mreq[0]}, 1);
    drv(0, 0, 0, 0, 32'h700, 0, 1, 0, 0);
    chk("drop mem_req after", {31'd0, o_mreq[0]}, 0);
    chk("drop d_addr_ok", {31'd0, o_daok[0]}, 0);
    drv(1, 32'h800, 0, 0, 0, 0, 1, 0, 0);
    chk("drop then i_addr_ok", {31'd0, o_iaok[0]}, 1);
    drv(0, 32'h800, 0, 0, 0, 0, 0, 1, 32'h99);
    chk("drop then i_data_ok", {31'd0, o_idok[0]}, 1);

    // fixed priority: dCache keeps winning at IDLE while it requests
    do_reset();
    for (int n = 0; n < 9; n++) begin
      drv(1, 32'h900, 1, 0, 32'hA00 + n, 0, 1, 0, 0);
      chk($sformatf("fixed%0d gnt_d", n), {31'd0, o_gntd[1]}, 1);
      chk($sformatf("fixed%0d i_addr_ok", n), {31'd0, o_iaok[1]}, 0);
      drv(1, 32'h900, (n < 8), 0, 32'hA00 + n, 0, 0, 1, n);
      chk($sformatf("fixed%0d d_data_ok", n), {31'd0, o_ddok[1]}, 1);
    end
    drv(1, 32'h900, 0, 0, 0, 0, 1, 0, 0);
    chk("fixed icache i_addr_ok", {31'd0, o_iaok[1]}, 1);
    chk("fixed icache mem_addr", o_maddr[1], 32'h900);
    drv(0, 32'h900, 0, 0, 0, 0, 0, 1, 32'h5);
    chk("fixed icache i_data_ok", {31'd0, o_idok[1]}, 1);

    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, 1 = round-robin arbitration; 0 = fixed dCache priority.
REQ-002 Parameter MAX_BURST, default 8, max consecutive transactions one master may hold the port (one cache line of words).
REQ-003 The block SHALL have one clock, clk, and an asynchronous active-low reset, resetn; resetn is the codebase's active-low reset name.
REQ-004 Ports (name  direction  width  meaning):
 clk  in  1  clock
 resetn  in  1  async active-low reset
 i_req  in  1  iCache read request
 i_addr  in  32  iCache word address
 i_rdata  out  32  iCache read data
 i_addr_ok  out  1  iCache address accepted
 i_data_ok  out  1  iCache data returned
 d_req  in  1  dCache request
 d_wen  in  1  dCache write enable
 d_addr  in  32  dCache word address
 d_wdata  in  32  dCache write data
 d_rdata  out  32  dCache read data
 d_addr_ok  out  1  dCache address accepted
 d_data_ok  out  1  dCache data returned / write done
 mem_req  out  1  memory request
 mem_wen  out  1  memory write enable
 mem_addr  out  32  memory address
 mem_wdata  out  32  memory write data
 mem_rdata  in  32  memory read data
 mem_addr_ok  in  1  memory address accepted
 mem_data_ok  in  1  memory data valid / write done
 gnt_d  out  1  1 while dCache holds the port (debug/perf)

Function
REQ-005 States: IDLE (no owner), ADDR (owner's request driven, awaiting mem_addr_ok), DATA (mem_req=0, awaiting mem_data_ok); at most one transaction outstanding.
REQ-006 IDLE: winner chosen combinationally and forwarded to mem_* in the same cycle (zero added latency); no request -> mem_req=0, stay IDLE.
REQ-007 Winner: only one requester -> it; both, RR_EN=0 -> dCache; both, RR_EN=1 -> master not granted last.
REQ-008 IDLE/ADDR with mem_addr_ok=1 -> owner latched, owner's addr_ok=1 that cycle, go DATA; without it -> ADDR (IDLE latches owner).
REQ-009 ADDR: mem_req/wen/addr/wdata follow the latched owner only; if owner drops req before mem_addr_ok -> IDLE, no addr_ok issued.
REQ-010 DATA: on mem_data_ok, owner's data_ok=1 and rdata=mem_rdata that cycle; non-owner data_ok/addr_ok SHALL stay 0.
REQ-011 On mem_data_ok, owner req=1 and burst_cnt<MAX_BURST-1 -> ADDR, same owner, burst_cnt+1; else -> IDLE, burst_cnt=0, last-grant := owner.
REQ-012 burst_cnt is $clog2(MAX_BURST) bits, saturating never required; cleared on every return to IDLE.
REQ-013 i_rdata and d_rdata SHALL both carry mem_rdata; only data_ok qualifies them.
REQ-014 mem_wen SHALL be 0 whenever the owner is iCache or mem_req=0.

Reset
REQ-015 resetn low SHALL immediately force IDLE, burst_cnt=0, last-grant=iCache, and all *_ok, mem_req, mem_wen, gnt_d to 0, including mid-transaction; outstanding memory responses after reset are dropped.

Structure
REQ-016 State enum and the master-ID encoding (IMASTER=0, DMASTER=1) SHALL live in a shared package with the cache constants.
REQ-017 One sub-module, rr_pick, SHALL implement REQ-007 combinationally; the FSM, counter and muxing stay in mem_arbiter.

Verification
REQ-018 Only i_req, addr 0x1000, mem_addr_ok same cycle, data_ok 2 cycles later with 0xDEADBEEF -> i_addr_ok cycle 0, i_data_ok and i_rdata=0xDEADBEEF cycle 2.
REQ-019 i_req and d_req together, RR_EN=1, after reset -> dCache served first (gnt_d=1), iCache next.
REQ-020 dCache holds d_req for 10 word writes, MAX_BURST=8, i_req high throughout -> 8 dCache transactions, then iCache granted, then dCache.
REQ-021 mem_addr_ok held low 5 cycles -> mem_addr/mem_wdata stable, no addr_ok to either master until accepted.
REQ-022 resetn pulled low in DATA -> next cycle IDLE, all outputs 0; late mem_data_ok produces no data_ok.
REQ-023 RR_EN=0, both requesting continuously -> dCache always wins at IDLE; iCache only after d_req drops.
